// File: rtl/hart_pkg.sv
// Shared RV64 hart constants: datapath/register widths and load funct3 encodings.
package hart_pkg;

  localparam int unsigned XLEN   = 64;
  localparam int unsigned REG_AW = 5;
  localparam int unsigned NREGS  = 1 << REG_AW;

  typedef enum logic [2:0] {
    F3_LB  = 3'b000,
    F3_LH  = 3'b001,
    F3_LW  = 3'b010,
    F3_LD  = 3'b011,
    F3_LBU = 3'b100,
    F3_LHU = 3'b101,
    F3_LWU = 3'b110
  } ld_f3_e;

endpackage

// File: rtl/load_ext.sv
// Load data alignment and sign/zero extension: picks the addressed lane of the raw
// doubleword, aligning the offset down to the access size.
module load_ext
  import hart_pkg::*;
(
  input  logic [XLEN-1:0] ld_data,
  input  logic [2:0]      ld_off,
  input  logic [2:0]      ld_f3,
  output logic [XLEN-1:0] ext
);

  logic [2:0]      off_m;
  logic [XLEN-1:0] shifted;

  always_comb begin
    unique case (ld_f3[1:0])
      2'b00:   off_m = ld_off;
      2'b01:   off_m = {ld_off[2:1], 1'b0};
      2'b10:   off_m = {ld_off[2], 2'b00};
      default: off_m = 3'b000;
    endcase
    shifted = ld_data >> {off_m, 3'b000};
  end

  always_comb begin
    ext = '0;
    case (ld_f3)
      F3_LB:   ext = {{56{shifted[7]}}, shifted[7:0]};
      F3_LH:   ext = {{48{shifted[15]}}, shifted[15:0]};
      F3_LW:   ext = {{32{shifted[31]}}, shifted[31:0]};
      F3_LD:   ext = shifted;
      F3_LBU:  ext = {56'd0, shifted[7:0]};
      F3_LHU:  ext = {48'd0, shifted[15:0]};
      F3_LWU:  ext = {32'd0, shifted[31:0]};
      default: ext = '0;
    endcase
  end

endmodule

// File: rtl/wb_stage.sv
// Writeback stage: load>ALU arbitration, registered regfile write, pending scoreboard.
// Optional operand bypass from the write register when WB_BYPASS_EN is defined.
module wb_stage
  import hart_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              alu_vld,
  output logic              alu_rdy,
  input  logic [XLEN-1:0]   alu_d,
  input  logic [REG_AW-1:0] alu_rd,
  input  logic              ld_vld,
  output logic              ld_rdy,
  input  logic [XLEN-1:0]   ld_data,
  input  logic [2:0]        ld_off,
  input  logic [2:0]        ld_f3,
  input  logic [REG_AW-1:0] ld_rd,
  input  logic              iss_vld,
  input  logic [REG_AW-1:0] iss_rd,
  input  logic [REG_AW-1:0] rs1,
  input  logic [REG_AW-1:0] rs2,
  output logic              haz1,
  output logic              haz2,
  output logic              haz_rd,
`ifdef WB_BYPASS_EN
  input  logic [XLEN-1:0]   rf_r1,
  input  logic [XLEN-1:0]   rf_r2,
  output logic [XLEN-1:0]   op1,
  output logic [XLEN-1:0]   op2,
`endif
  output logic [XLEN-1:0]   d,
  output logic [REG_AW-1:0] rd,
  output logic              wr
);

  logic [XLEN-1:0]   ld_ext;
  logic [XLEN-1:0]   d_d, d_q;
  logic [REG_AW-1:0] rd_d, rd_q;
  logic              wr_d, wr_q;
  logic [NREGS-1:0]  pend_d, pend_q;

  load_ext u_load_ext (
    .ld_data (ld_data),
    .ld_off  (ld_off),
    .ld_f3   (ld_f3),
    .ext     (ld_ext)
  );

  assign ld_rdy  = !flush;
  assign alu_rdy = !ld_vld && !flush;

  always_comb begin
    d_d  = d_q;
    rd_d = rd_q;
    wr_d = 1'b0;
    if (ld_vld && ld_rdy) begin
      d_d  = ld_ext;
      rd_d = ld_rd;
      wr_d = (ld_rd != '0);
    end else if (alu_vld && alu_rdy) begin
      d_d  = alu_d;
      rd_d = alu_rd;
      wr_d = (alu_rd != '0);
    end
  end

  // Clear before set so a same-cycle issue of the retiring register stays pending.
  always_comb begin
    pend_d = pend_q;
    if (wr_q) pend_d[rd_q] = 1'b0;
    if (iss_vld && iss_rd != '0) pend_d[iss_rd] = 1'b1;
    if (flush) pend_d = '0;
    pend_d[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      d_q    <= '0;
      rd_q   <= '0;
      wr_q   <= 1'b0;
      pend_q <= '0;
    end else begin
      d_q    <= d_d;
      rd_q   <= rd_d;
      wr_q   <= wr_d;
      pend_q <= pend_d;
    end
  end

  assign d      = d_q;
  assign rd     = rd_q;
  assign wr     = wr_q;
  assign haz_rd = pend_q[iss_rd];

`ifdef WB_BYPASS_EN
  logic byp1, byp2;
  assign byp1 = wr_q && (rd_q != '0) && (rd_q == rs1);
  assign byp2 = wr_q && (rd_q != '0) && (rd_q == rs2);
  assign op1  = byp1 ? d_q : rf_r1;
  assign op2  = byp2 ? d_q : rf_r2;
  assign haz1 = pend_q[rs1] && !byp1;
  assign haz2 = pend_q[rs2] && !byp2;
`else
  assign haz1 = pend_q[rs1];
  assign haz2 = pend_q[rs2];
`endif

endmodule

// File: tb/tb_wb_stage.sv
// Directed bench for wb_stage (default build): arbitration, load extension,
// scoreboard, flush, x0 writes and asynchronous reset.
module tb_wb_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        alu_vld, alu_rdy;
  logic [63:0] alu_d;
  logic [4:0]  alu_rd;
  logic        ld_vld, ld_rdy;
  logic [63:0] ld_data;
  logic [2:0]  ld_off, ld_f3;
  logic [4:0]  ld_rd;
  logic        iss_vld;
  logic [4:0]  iss_rd, rs1, rs2;
  logic        haz1, haz2, haz_rd;
  logic [63:0] d;
  logic [4:0]  rd;
  logic        wr;
`ifdef WB_BYPASS_EN
  logic [63:0] rf_r1, rf_r2, op1, op2;
  assign rf_r1 = '0;
  assign rf_r2 = '0;
`endif

  int n_chk = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  wb_stage dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .flush   (flush),
    .alu_vld (alu_vld),
    .alu_rdy (alu_rdy),
    .alu_d   (alu_d),
    .alu_rd  (alu_rd),
    .ld_vld  (ld_vld),
    .ld_rdy  (ld_rdy),
    .ld_data (ld_data),
    .ld_off  (ld_off),
    .ld_f3   (ld_f3),
    .ld_rd   (ld_rd),
    .iss_vld (iss_vld),
    .iss_rd  (iss_rd),
    .rs1     (rs1),
    .rs2     (rs2),
    .haz1    (haz1),
    .haz2    (haz2),
    .haz_rd  (haz_rd),
`ifdef WB_BYPASS_EN
    .rf_r1   (rf_r1),
    .rf_r2   (rf_r2),
    .op1     (op1),
    .op2     (op2),
`endif
    .d       (d),
    .rd      (rd),
    .wr      (wr)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [2:0]  f3;
    logic [2:0]  off;
    logic [63:0] exp;
  } ld_vec_t;

  ld_vec_t lv[8];

  initial begin
    lv[0] = '{3'b000, 3'd7, 64'hFFFF_FFFF_FFFF_FF80};  // LB
    lv[1] = '{3'b100, 3'd7, 64'h0000_0000_0000_0080};  // LBU
    lv[2] = '{3'b001, 3'd7, 64'hFFFF_FFFF_FFFF_80FF};  // LH, off masked to 6
    lv[3] = '{3'b101, 3'd6, 64'h0000_0000_0000_80FF};  // LHU
    lv[4] = '{3'b010, 3'd5, 64'hFFFF_FFFF_80FF_0000};  // LW, off masked to 4
    lv[5] = '{3'b110, 3'd4, 64'h0000_0000_80FF_0000};  // LWU
    lv[6] = '{3'b011, 3'd7, 64'h80FF_0000_0000_0000};  // LD ignores offset
    lv[7] = '{3'b111, 3'd0, 64'h0000_0000_0000_0000};  // reserved

    rst_n = 1'b0; flush = 1'b0;
    alu_vld = 1'b0; alu_d = '0; alu_rd = '0;
    ld_vld = 1'b0; ld_data = '0; ld_off = '0; ld_f3 = '0; ld_rd = '0;
    iss_vld = 1'b0; iss_rd = '0; rs1 = 5'd3; rs2 = 5'd9;
    #12;
    check_eq("rst_wr", wr, 0);
    check_eq("rst_d", d, 0);
    check_eq("rst_rd", rd, 0);
    check_eq("rst_haz1", haz1, 0);
    rst_n = 1'b1;
    tick();

    // ALU only
    alu_vld = 1'b1; alu_d = 64'h1234; alu_rd = 5'd5;
    #1 check_eq("alu_rdy", alu_rdy, 1);
    tick();
    alu_vld = 1'b0;
    check_eq("alu_wr", wr, 1);
    check_eq("alu_rd", rd, 5);
    check_eq("alu_d", d, 64'h1234);
    tick();
    check_eq("idle_wr", wr, 0);
    check_eq("idle_d_hold", d, 64'h1234);

    // Load beats ALU
    ld_vld = 1'b1; ld_data = 64'h80FF_0000_0000_0000; ld_off = 3'd7; ld_f3 = 3'b000;
    ld_rd = 5'd10;
    alu_vld = 1'b1; alu_d = 64'h55; alu_rd = 5'd6;
    #1;
    check_eq("arb_alu_rdy", alu_rdy, 0);
    check_eq("arb_ld_rdy", ld_rdy, 1);
    tick();
    ld_vld = 1'b0;
    check_eq("arb_ld_rd", rd, 10);
    check_eq("arb_ld_d", d, 64'hFFFF_FFFF_FFFF_FF80);
    tick();
    alu_vld = 1'b0;
    check_eq("arb_alu_wr", wr, 1);
    check_eq("arb_alu_rd2", rd, 6);
    check_eq("arb_alu_d2", d, 64'h55);

    // Load extension table
    for (int i = 0; i < 8; i++) begin
      ld_vld = 1'b1; ld_f3 = lv[i].f3; ld_off = lv[i].off; ld_rd = 5'd11;
      tick();
      ld_vld = 1'b0;
      check_eq($sformatf("ldext_%0d_d", i), d, lv[i].exp);
      check_eq($sformatf("ldext_%0d_wr", i), wr, 1);
    end
    tick();

    // Scoreboard set, hold through write cycle, clear after
    iss_vld = 1'b1; iss_rd = 5'd7;
    tick();
    iss_vld = 1'b0; rs1 = 5'd7;
    #1;
    check_eq("sb_haz1", haz1, 1);
    check_eq("sb_haz_rd", haz_rd, 1);
    alu_vld = 1'b1; alu_d = 64'h77; alu_rd = 5'd7;
    tick();
    alu_vld = 1'b0;
    check_eq("sb_wr7", wr, 1);
    check_eq("sb_haz1_during_wr", haz1, 1);
    tick();
    check_eq("sb_haz1_clear", haz1, 0);

    // Same-cycle set and clear: set wins
    iss_vld = 1'b1; iss_rd = 5'd7;
    alu_vld = 1'b1; alu_rd = 5'd7;
    tick();
    alu_vld = 1'b0;
    check_eq("sc_wr7", wr, 1);
    tick();
    iss_vld = 1'b0;
    #1 check_eq("sc_haz1_kept", haz1, 1);
    alu_vld = 1'b1; alu_rd = 5'd7;
    tick();
    alu_vld = 1'b0;
    tick();
    check_eq("sc_haz1_cleared", haz1, 0);

    // Flush with pending {3,9}
    iss_vld = 1'b1; iss_rd = 5'd3;
    tick();
    iss_rd = 5'd9;
    tick();
    iss_vld = 1'b0; rs1 = 5'd3; rs2 = 5'd9;
    #1;
    check_eq("fl_pre_haz1", haz1, 1);
    check_eq("fl_pre_haz2", haz2, 1);
    alu_vld = 1'b1; alu_d = 64'hAB; alu_rd = 5'd12;
    tick();
    flush = 1'b1; alu_d = 64'hCD; alu_rd = 5'd13;
    iss_vld = 1'b1; iss_rd = 5'd4;
    #1;
    check_eq("fl_alu_rdy", alu_rdy, 0);
    check_eq("fl_inflight_wr", wr, 1);
    check_eq("fl_inflight_rd", rd, 12);
    check_eq("fl_inflight_d", d, 64'hAB);
    tick();
    flush = 1'b0; iss_vld = 1'b0;
    #1;
    check_eq("fl_haz1", haz1, 0);
    check_eq("fl_haz2", haz2, 0);
    check_eq("fl_iss_dropped", haz_rd, 0);
    check_eq("fl_no_wr", wr, 0);
    tick();
    alu_vld = 1'b0;
    check_eq("fl_retry_rd", rd, 13);
    check_eq("fl_retry_d", d, 64'hCD);

    // Write to x0 is consumed but not written
    alu_vld = 1'b1; alu_d = 64'h99; alu_rd = 5'd0;
    #1 check_eq("x0_rdy", alu_rdy, 1);
    tick();
    alu_vld = 1'b0;
    check_eq("x0_wr", wr, 0);

    // Asynchronous reset drops an in-flight write
    alu_vld = 1'b1; alu_d = 64'h5A; alu_rd = 5'd20;
    tick();
    alu_vld = 1'b0;
    check_eq("ar_pre_wr", wr, 1);
    #2 rst_n = 1'b0;
    #1;
    check_eq("ar_wr", wr, 0);
    check_eq("ar_d", d, 0);
    #3 rst_n = 1'b1;
    tick();

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
